// File: rtl/frame_buffer_if.sv
// Writer-side port of frame_buffer: pixel write handshake, swap request/ack
// and the currently displayed bank.
interface frame_buffer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [4:0] wr_x;
    logic [2:0] wr_y;
    logic [2:0] wr_rgb;
    logic       swap_req;
    logic       swap_ack;
    logic       front_sel;

    modport master (
        output wr_valid, wr_x, wr_y, wr_rgb, swap_req,
        input  wr_ready, swap_ack, front_sel
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_rgb, swap_req,
        output wr_ready, swap_ack, front_sel
    );
endinterface

// File: rtl/frame_buffer.sv
// Double-buffered 3-bit pixel store: front bank read by the matrix sequencer,
// back bank written by the host, swap deferred to a frame wrap.
// Optional macro FRAME_BUFFER_CLEAR_ON_SWAP_EN zeroes the new back bank after each swap.
module frame_buffer #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] row,
    input  logic [7:0] col,
    output logic [2:0] rgb,
    frame_buffer_if.slave wr
);

    localparam int unsigned CLR_CYCLES = ROWS * COLS;
    localparam int unsigned RW         = $clog2(ROWS);
    localparam int unsigned CW         = $clog2(COLS);
    localparam int unsigned AW         = RW + CW;

    typedef enum logic [1:0] {
        IDLE,
        SWAP_PEND,
        CLEAR
    } state_t;

    state_t                            state_q, state_d;
    logic [1:0][CLR_CYCLES-1:0][2:0]   mem_q;
    logic                              front_sel_q, front_sel_d;
    logic [2:0]                        rgb_q, rgb_d;
    logic                              wr_ready_q, wr_ready_d;
    logic                              swap_ack_q, swap_ack_d;
    logic [2:0]                        prev_row_q;

    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic          rd_in_range;
    logic          wr_in_range;
    logic          wr_fire;
    logic          wrap;

    assign rd_addr     = {row[RW-1:0], col[CW-1:0]};
    assign wr_addr     = {wr.wr_y[RW-1:0], wr.wr_x[CW-1:0]};
    assign rd_in_range = (32'(row) < ROWS) && (32'(col) < COLS);
    assign wr_in_range = (32'(wr.wr_x) < COLS) && (32'(wr.wr_y) < ROWS);
    assign wr_fire     = wr.wr_valid && wr_ready_q && wr_in_range;
    assign wrap        = (prev_row_q == 3'(ROWS - 1)) && (row == '0);

`ifdef FRAME_BUFFER_CLEAR_ON_SWAP_EN
    logic [AW-1:0] clr_q, clr_d;
`endif

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        swap_ack_d  = 1'b0;
`ifdef FRAME_BUFFER_CLEAR_ON_SWAP_EN
        clr_d       = clr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (wr.swap_req) state_d = SWAP_PEND;
            end
            SWAP_PEND: begin
                if (wrap) begin
                    front_sel_d = ~front_sel_q;
`ifdef FRAME_BUFFER_CLEAR_ON_SWAP_EN
                    state_d     = CLEAR;
`else
                    state_d     = IDLE;
                    swap_ack_d  = 1'b1;
`endif
                end
            end
            CLEAR: begin
`ifdef FRAME_BUFFER_CLEAR_ON_SWAP_EN
                if (32'(clr_q) == CLR_CYCLES - 1) begin
                    clr_d      = '0;
                    state_d    = IDLE;
                    swap_ack_d = 1'b1;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        wr_ready_d = (state_d == IDLE);
        // Read through the post-edge bank so the row-0 address on the swap edge sees the new frame.
        rgb_d      = rd_in_range ? mem_q[front_sel_d][rd_addr] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            rgb_q       <= '0;
            wr_ready_q  <= 1'b0;
            swap_ack_q  <= 1'b0;
            prev_row_q  <= '0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            rgb_q       <= rgb_d;
            wr_ready_q  <= wr_ready_d;
            swap_ack_q  <= swap_ack_d;
            prev_row_q  <= row;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
        end else begin
            if (wr_fire) mem_q[~front_sel_q][wr_addr] <= wr.wr_rgb;
`ifdef FRAME_BUFFER_CLEAR_ON_SWAP_EN
            if (state_q == CLEAR) mem_q[~front_sel_q][clr_q] <= '0;
`endif
        end
    end

`ifdef FRAME_BUFFER_CLEAR_ON_SWAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) clr_q <= '0;
        else      clr_q <= clr_d;
    end
`endif

    assign rgb          = rgb_q;
    assign wr.wr_ready  = wr_ready_q;
    assign wr.swap_ack  = swap_ack_q;
    assign wr.front_sel = front_sel_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer: driver predicts each cycle's outputs from a
// frame-level model (two pixel arrays, pending-swap flag); a monitor compares.
module tb_frame_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] row;
    logic [7:0] col;
    logic [2:0] rgb;

    frame_buffer_if bus();

    frame_buffer #(.ROWS(8), .COLS(32)) dut (
        .clk (clk),
        .rst (rst),
        .row (row),
        .col (col),
        .rgb (rgb),
        .wr  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] rgb;
        logic       ready;
        logic       ack;
        logic       front;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: whole frames, a pending flag and a clear-busy countdown.
    logic [2:0] m_bank [2][8][32];
    bit         m_front;
    bit         m_pend;
    bit         m_ready;
    int         m_clr_left;
    logic [2:0] m_prev;

    int scan_r = 0;
    int scan_c = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 32; x++)
                    m_bank[b][y][x] = 3'd0;
        m_front    = 1'b0;
        m_pend     = 1'b0;
        m_ready    = 1'b0;
        m_clr_left = 0;
        m_prev     = 3'd0;
    endtask

    // Drive one cycle's inputs and push the outputs expected after the next edge.
    task automatic step(input logic [2:0] r, input logic [7:0] c, input logic wv,
                        input logic [4:0] x, input logic [2:0] y, input logic [2:0] px,
                        input logic sr);
        exp_t e;
        bit   wrap;
        row          = r;
        col          = c;
        bus.wr_valid = wv;
        bus.wr_x     = x;
        bus.wr_y     = y;
        bus.wr_rgb   = px;
        bus.swap_req = sr;
        wrap  = (m_prev == 3'd7) && (r == 3'd0);
        e.ack = 1'b0;
        if (m_pend) begin
            if (wrap) begin
                m_front = !m_front;
                m_pend  = 1'b0;
`ifdef FRAME_BUFFER_CLEAR_ON_SWAP_EN
                m_clr_left = 256;
                for (int yy = 0; yy < 8; yy++)
                    for (int xx = 0; xx < 32; xx++)
                        m_bank[!m_front][yy][xx] = 3'd0;
`else
                e.ack = 1'b1;
`endif
            end
        end else if (m_clr_left > 0) begin
            m_clr_left--;
            if (m_clr_left == 0) e.ack = 1'b1;
        end else begin
            if (wv && m_ready) m_bank[!m_front][y][x] = px;
            if (sr) m_pend = 1'b1;
        end
        m_ready = !m_pend && (m_clr_left == 0);
        m_prev  = r;
        e.rgb   = (c < 8'd32) ? m_bank[m_front][r][c[4:0]] : 3'd0;
        e.ready = m_ready;
        e.front = m_front;
        expq.push_back(e);
    endtask

    task automatic cyc(input logic [2:0] r, input logic [7:0] c, input logic wv,
                       input logic [4:0] x, input logic [2:0] y, input logic [2:0] px,
                       input logic sr);
        @(negedge clk);
        step(r, c, wv, x, y, px, sr);
    endtask

    task automatic scan_next();
        scan_c++;
        if (scan_c == 40) begin
            scan_c = 0;
            scan_r = (scan_r + 1) % 8;
        end
    endtask

    // Sequencer-like raster (cols 0..39) with occasional random columns.
    task automatic run(input int n, input int unsigned wpct, input int unsigned spm);
        for (int i = 0; i < n; i++) begin
            logic [7:0] c;
            scan_next();
            c = 8'(scan_c);
            if ($urandom_range(15) == 0) c = 8'($urandom_range(255));
            cyc(3'(scan_r), c, $urandom_range(99) < wpct, 5'($urandom), 3'($urandom),
                3'($urandom), $urandom_range(999) < spm);
        end
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        rst          = 1'b0;
        bus.wr_valid = 1'b0;
        bus.swap_req = 1'b0;
        model_reset();
        #1;
        chk("rst_rgb",       32'(rgb),           32'd0);
        chk("rst_front_sel", 32'(bus.front_sel), 32'd0);
        chk("rst_wr_ready",  32'(bus.wr_ready),  32'd0);
        chk("rst_swap_ack",  32'(bus.swap_ack),  32'd0);
        repeat (hold) @(negedge clk);
        rst = 1'b1;
        step(3'(scan_r), 8'(scan_c), 1'b0, 5'd0, 3'd0, 3'd0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b1 && expq.size() != 0) begin
                e = expq.pop_front();
                chk("rgb",       32'(rgb),           32'(e.rgb));
                chk("wr_ready",  32'(bus.wr_ready),  32'(e.ready));
                chk("swap_ack",  32'(bus.swap_ack),  32'(e.ack));
                chk("front_sel", 32'(bus.front_sel), 32'(e.front));
            end
        end
    end

    initial begin : driver
        rst          = 1'b0;
        row          = 3'd0;
        col          = 8'd0;
        bus.wr_valid = 1'b0;
        bus.wr_x     = 5'd0;
        bus.wr_y     = 3'd0;
        bus.wr_rgb   = 3'd0;
        bus.swap_req = 1'b0;
        model_reset();
        do_reset(3);

        // Blank frame reads back as zero everywhere.
        run(330, 0, 0);

        // Write two pixels, then request a swap mid-frame at row 2.
        cyc(3'd0, 8'd0, 1'b1, 5'd5,  3'd3, 3'b101, 1'b0);
        cyc(3'd0, 8'd1, 1'b1, 5'd31, 3'd0, 3'b110, 1'b0);
        cyc(3'd2, 8'd0, 1'b0, 5'd0,  3'd0, 3'd0,   1'b1);
        for (int r = 3; r < 8; r++)
            for (int k = 0; k < 4; k++)
                cyc(3'(r), 8'(k), 1'b1, 5'($urandom), 3'($urandom), 3'($urandom), k == 1);
        cyc(3'd0, 8'd0,  1'b1, 5'd7, 3'd1, 3'd2, 1'b0);
        cyc(3'd3, 8'd5,  1'b0, 5'd0, 3'd0, 3'd0, 1'b0);
        cyc(3'd0, 8'd31, 1'b0, 5'd0, 3'd0, 3'd0, 1'b0);
        cyc(3'd3, 8'd40, 1'b0, 5'd0, 3'd0, 3'd0, 1'b0);
        cyc(3'd3, 8'd6,  1'b0, 5'd0, 3'd0, 3'd0, 1'b0);
        run(300, 0, 0);

        // Second swap brings the original bank back to the front.
        cyc(3'd2, 8'd0, 1'b0, 5'd0, 3'd0, 3'd0, 1'b1);
        run(700, 10, 0);

        // Randomized writes and swap requests.
        run(4000, 30, 8);

        // Reset while a swap is pending.
        cyc(3'd2, 8'd3, 1'b1, 5'd9, 3'd4, 3'd7, 1'b1);
        cyc(3'd3, 8'd3, 1'b1, 5'd9, 3'd4, 3'd7, 1'b0);
        do_reset(2);
        run(400, 20, 5);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
- Double-buffered pixel store that sits directly downstream of the matrix sequencer.
- The sequencer's row/col addresses the front bank, and the block returns the 1-bit R/G/B value of that pixel. This value is the serial data shifted into the matrix on sclk.
- A writer (host/animation logic) fills the back bank through a valid/ready port. It then requests a swap, which takes effect only at a frame boundary so no displayed frame tears.

Parameters:
- ROWS, 8, rows per frame; row index width 3.
- COLS, 32, columns per row; only col[4:0] is used for addressing.
- CLR_CYCLES, ROWS*COLS (local, derived), cycles needed to clear one bank.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low (asserted at 0)
- row  input  3  row currently being written, from sequencer
- col  input  8  column currently being written, from sequencer
- rgb  output  3  {R,G,B} of front[row][col]; registered
- wr_valid  input  1  write request
- wr_ready  output  1  write accepted when wr_valid && wr_ready
- wr_x  input  5  write column
- wr_y  input  3  write row
- wr_rgb  input  3  write pixel value
- swap_req  input  1  request front/back exchange (level; sampled in IDLE)
- swap_ack  output  1  one-cycle pulse: swap (and clear, if enabled) complete
- front_sel  output  1  bank currently displayed

Behaviour:
- Storage: two banks of ROWS*COLS x 3 bits. Bank index = front_sel for reads and ~front_sel for writes.
- Reset (rst=0, async):
  - All pixels in both banks = 0.
  - rgb=0, front_sel=0, wr_ready=0, swap_ack=0, state=IDLE, prev_row=0, clear counter=0.
  - wr_ready rises the first cycle after rst deasserts.
- Read path:
  - Each clk, rgb <= front[row][col[4:0]]. Latency is 1 cycle.
  - If col >= COLS or row >= ROWS, rgb <= 0.
  - Reads never stall.
- Frame boundary: prev_row <= row every clk. wrap = (prev_row == ROWS-1) && (row == 0).
- Write path:
  - Accept when wr_valid && wr_ready. Then back[wr_y][wr_x] <= wr_rgb on that edge.
  - wr_x >= COLS: the write is accepted and discarded.
- FSM states: IDLE, SWAP_PEND, CLEAR.
  - IDLE: wr_ready=1.
    - swap_req=1 -> SWAP_PEND.
    - A write accepted in the same cycle as swap_req still lands in the back bank.
  - SWAP_PEND: wr_ready=0.
    - On wrap: front_sel toggles on that edge. Next state is CLEAR if the feature is enabled, else IDLE with swap_ack=1 for the next cycle.
    - swap_req is ignored while in this state.
  - CLEAR: wr_ready=0.
    - Clears one pixel per cycle of the new back bank, address = counter 0..CLR_CYCLES-1.
    - On counter == CLR_CYCLES-1: counter <= 0, state -> IDLE, swap_ack=1 for the next cycle.
- swap_ack is a registered single-cycle pulse. It is never asserted twice for one request.
- swap_req held high after ack starts a new swap request from IDLE.
- Reset mid-swap or mid-clear aborts to the reset state: banks zeroed, front_sel=0, no ack.
- Read data reflects the new front bank starting with the row-0 address presented on the swap edge. The first post-swap rgb appears one cycle later.

Optional Feature:
- Macro: FRAME_BUFFER_CLEAR_ON_SWAP_EN.
- Defined: after each swap, enter CLEAR and zero the new back bank over CLR_CYCLES (256) cycles. wr_ready stays low and swap_ack is delayed until the clear completes.
- Not defined: no CLEAR state. The back bank keeps the previously displayed frame. swap_ack pulses the cycle after the bank flip and wr_ready returns high in that same cycle.

Test Plan:
- Reset: drive rst=0 mid-operation after writes -> rgb=0, front_sel=0, wr_ready=0, swap_ack=0. One cycle after release wr_ready=1, and a read of any (row,col) returns 0.
- Write/swap/read: write (x=5,y=3,rgb=3'b101), assert swap_req, then sweep row 7->0. Expect front_sel=1 on the wrap edge, and row=3,col=5 yields rgb=3'b101 one cycle after the address is presented. Other pixels = 0.
- Deferred swap: assert swap_req while row=2 -> front_sel unchanged through rows 3..7 and wr_ready=0. Toggle occurs only on the 7->0 transition, and swap_ack is a single 1-cycle pulse.
- Backpressure: hold wr_valid=1 during SWAP_PEND -> no write occurs until wr_ready=1. Then exactly one write per accepted cycle lands in the bank opposite front_sel.
- Bounds: col=8'd40 -> rgb=0. wr_x=5'd31 is written and read back. A rapid second swap_req during SWAP_PEND produces no extra ack.
- With FRAME_BUFFER_CLEAR_ON_SWAP_EN: after swap, wr_ready=0 for 256 cycles and swap_ack comes at the end. On the next swap, the old bank reads back all 0 except pixels written after the clear.
